// File: rtl/delay_probe_rx_pkg.sv
// Shared constants and FSM encoding for the latency-probe receiver.
// Field offsets are byte positions from the first byte of the frame.
package delay_probe_rx_pkg;

   localparam logic [15:0] PROBE_ETYPE_DEF = 16'h88B5;
   localparam int unsigned OFS_ETYPE       = 12;
   localparam int unsigned OFS_SEQ         = 14;
   localparam int unsigned OFS_TS          = 18;
   localparam int unsigned SEQ_BYTES       = 4;
   localparam int unsigned BCNT_W          = 11;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StSeq,
      StTsf,
      StBody,
      StDrop,
      StWait
   } state_e;

endpackage

// File: rtl/delay_probe_rx_if.sv
// MAC RX client interface: byte stream and frame status from the MAC,
// static receive configuration back to the MAC.
interface delay_probe_rx_if;

   logic [7:0] mac_rx_data;
   logic       mac_rx_dvld;
   logic       mac_rx_goodframe;
   logic       mac_rx_badframe;
   logic       conf_rx_en;
   logic       conf_rx_jumbo_en;
   logic       conf_rx_no_chk_crc;

   modport master (
      output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
      input  conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc
   );

   modport slave (
      input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
      output conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc
   );

endinterface

// File: rtl/delay_probe_rx_stats.sv
// Running delay statistics: min/max delay, good-probe count and sequence-gap count.
// A clear in the same cycle as a commit leaves everything in the cleared state.
module delay_probe_rx_stats #(
   parameter int unsigned TS_W = 32
) (
   input  logic            rx_clk,
   input  logic            reset_n,
   input  logic            i_commit,
   input  logic            i_clear,
   input  logic [TS_W-1:0] i_delay,
   input  logic [31:0]     i_seq,
   output logic [TS_W-1:0] o_delay_min,
   output logic [TS_W-1:0] o_delay_max,
   output logic [31:0]     o_probe_cnt,
   output logic [31:0]     o_gap_cnt
);

   logic [TS_W-1:0] r_min;
   logic [TS_W-1:0] r_max;
   logic [31:0]     r_probe_cnt;
   logic [31:0]     r_gap_cnt;
   logic [31:0]     r_last_seq;
   logic            r_first;

   always_ff @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_min       <= '1;
         r_max       <= '0;
         r_probe_cnt <= '0;
         r_gap_cnt   <= '0;
         r_last_seq  <= '0;
         r_first     <= 1'b1;
      end else if (i_clear) begin
         r_min       <= '1;
         r_max       <= '0;
         r_probe_cnt <= '0;
         r_gap_cnt   <= '0;
         r_first     <= 1'b1;
      end else if (i_commit) begin
         if (i_delay < r_min) r_min <= i_delay;
         if (i_delay > r_max) r_max <= i_delay;
         r_probe_cnt <= r_probe_cnt + 32'd1;
         if (!r_first && (i_seq != r_last_seq + 32'd1)) r_gap_cnt <= r_gap_cnt + 32'd1;
         r_first    <= 1'b0;
         r_last_seq <= i_seq;
      end
   end

   assign o_delay_min = r_min;
   assign o_delay_max = r_max;
   assign o_probe_cnt = r_probe_cnt;
   assign o_gap_cnt   = r_gap_cnt;

endmodule

// File: rtl/delay_probe_rx.sv
// Receive endpoint for looped-back latency probes: parses frames from the MAC RX client,
// timestamps arrival and publishes one-way delay plus loss/error statistics.
module delay_probe_rx
   import delay_probe_rx_pkg::*;
#(
   parameter int unsigned TS_W        = 32,
   parameter logic [15:0] PROBE_ETYPE = PROBE_ETYPE_DEF,
   parameter int unsigned STAT_TMO    = 16
) (
   input  logic             rx_clk,
   input  logic             reset_n,
   delay_probe_rx_if.slave  mac,
   input  logic [TS_W-1:0]  i_timer_now,
   input  logic             i_clear_stats,
   output logic             o_meas_valid,
   output logic [31:0]      o_meas_seq,
   output logic [TS_W-1:0]  o_meas_delay,
   output logic [TS_W-1:0]  o_delay_min,
   output logic [TS_W-1:0]  o_delay_max,
   output logic [31:0]      o_probe_cnt,
   output logic [31:0]      o_bad_cnt,
   output logic [31:0]      o_other_cnt,
   output logic [31:0]      o_gap_cnt
);

   localparam int unsigned       TsBytes    = TS_W / 8;
   localparam logic [BCNT_W-1:0] IdxEtHi    = BCNT_W'(OFS_ETYPE);
   localparam logic [BCNT_W-1:0] IdxEtLo    = BCNT_W'(OFS_ETYPE + 1);
   localparam logic [BCNT_W-1:0] IdxSeqLast = BCNT_W'(OFS_SEQ + SEQ_BYTES - 1);
   localparam logic [BCNT_W-1:0] IdxTsLast  = BCNT_W'(OFS_TS + TsBytes - 1);
   localparam logic [BCNT_W-1:0] CntMax     = '1;

   state_e            r_state, w_state_nxt;
   logic              r_dvld;
   logic [BCNT_W-1:0] r_cnt, w_idx;
   logic [7:0]        r_et_hi;
   logic [31:0]       r_seq;
   logic [TS_W-1:0]   r_ts, r_arr;
   logic [15:0]       r_tmo, w_tmr;
   logic              r_probe;
   logic              r_meas_valid;
   logic [31:0]       r_meas_seq, r_bad_cnt, r_other_cnt;
   logic [TS_W-1:0]   r_meas_delay;
   logic              w_sof, w_eof, w_wait, w_probe_fr, w_tmo, w_restart;
   logic              w_commit, w_bad_inc, w_other_inc;
   logic [TS_W-1:0]   w_delay;

   assign mac.conf_rx_en         = 1'b1;
   assign mac.conf_rx_jumbo_en   = 1'b0;
   assign mac.conf_rx_no_chk_crc = 1'b0;

   // The eof cycle (first dvld-low cycle) already counts as status wait, timer = 1.
   always_comb begin
      w_sof       = mac.mac_rx_dvld & ~r_dvld;
      w_idx       = w_sof ? '0 : r_cnt;
      w_eof       = (r_state inside {StHdr, StSeq, StTsf, StBody, StDrop}) & ~mac.mac_rx_dvld;
      w_wait      = (r_state == StWait) | w_eof;
      w_probe_fr  = (r_state == StWait) ? r_probe : (r_state == StBody);
      w_tmr       = (r_state == StWait) ? r_tmo : 16'd1;
      w_tmo       = (w_tmr >= 16'(STAT_TMO));
      w_restart   = (r_state == StWait) & w_sof;
      w_delay     = r_arr - r_ts;
      w_commit    = 1'b0;
      w_bad_inc   = 1'b0;
      w_other_inc = 1'b0;
      w_state_nxt = r_state;
      if (w_wait) begin
         if (mac.mac_rx_badframe) w_bad_inc = 1'b1;
         else if (mac.mac_rx_goodframe) begin
            w_commit    = w_probe_fr;
            w_other_inc = ~w_probe_fr;
         end else if (w_tmo || w_restart) w_bad_inc = 1'b1;

         if (w_restart) w_state_nxt = StHdr;
         else if (mac.mac_rx_badframe || mac.mac_rx_goodframe || w_tmo) w_state_nxt = StIdle;
         else w_state_nxt = StWait;
      end else if (mac.mac_rx_dvld) begin
         case (r_state)
            StIdle: if (w_sof) w_state_nxt = StHdr;
            StHdr:  if (w_idx == IdxEtLo) begin
                       w_state_nxt = ({r_et_hi, mac.mac_rx_data} == PROBE_ETYPE) ? StSeq : StDrop;
                    end
            StSeq:  if (w_idx == IdxSeqLast) w_state_nxt = StTsf;
            StTsf:  if (w_idx == IdxTsLast) w_state_nxt = StBody;
            default: ;
         endcase
      end
   end

   always_ff @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_dvld resets high so a frame already in flight at reset release is never parsed.
   always_ff @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dvld  <= 1'b1;
         r_cnt   <= '0;
         r_et_hi <= '0;
         r_seq   <= '0;
         r_ts    <= '0;
         r_arr   <= '0;
         r_tmo   <= '0;
         r_probe <= 1'b0;
      end else begin
         r_dvld <= mac.mac_rx_dvld;
         if (mac.mac_rx_dvld) r_cnt <= (w_idx == CntMax) ? CntMax : w_idx + 1'b1;
         if (mac.mac_rx_dvld && r_state == StHdr && w_idx == IdxEtHi) r_et_hi <= mac.mac_rx_data;
         if (mac.mac_rx_dvld && r_state == StSeq) r_seq <= {r_seq[23:0], mac.mac_rx_data};
         if (mac.mac_rx_dvld && r_state == StTsf) r_ts <= {r_ts[TS_W-9:0], mac.mac_rx_data};
         if (w_sof) r_arr <= i_timer_now;
         if (w_wait) r_tmo <= w_tmr + 16'd1;
         if (w_eof) r_probe <= (r_state == StBody);
      end
   end

   always_ff @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meas_valid <= 1'b0;
         r_meas_seq   <= '0;
         r_meas_delay <= '0;
         r_bad_cnt    <= '0;
         r_other_cnt  <= '0;
      end else begin
         r_meas_valid <= w_commit;
         if (w_commit) begin
            r_meas_seq   <= r_seq;
            r_meas_delay <= w_delay;
         end
         if (i_clear_stats) begin
            r_bad_cnt   <= '0;
            r_other_cnt <= '0;
         end else begin
            if (w_bad_inc) r_bad_cnt <= r_bad_cnt + 32'd1;
            if (w_other_inc) r_other_cnt <= r_other_cnt + 32'd1;
         end
      end
   end

   delay_probe_rx_stats #(
      .TS_W (TS_W)
   ) u_stats (
      .rx_clk      (rx_clk),
      .reset_n     (reset_n),
      .i_commit    (w_commit),
      .i_clear     (i_clear_stats),
      .i_delay     (w_delay),
      .i_seq       (r_seq),
      .o_delay_min (o_delay_min),
      .o_delay_max (o_delay_max),
      .o_probe_cnt (o_probe_cnt),
      .o_gap_cnt   (o_gap_cnt)
   );

   assign o_meas_valid = r_meas_valid;
   assign o_meas_seq   = r_meas_seq;
   assign o_meas_delay = r_meas_delay;
   assign o_bad_cnt    = r_bad_cnt;
   assign o_other_cnt  = r_other_cnt;

endmodule

// File: tb/tb_delay_probe_rx.sv
// Directed bench for delay_probe_rx: probe parsing, delay wrap, gaps, status handling,
// timeouts, clear/commit collision and mid-frame reset.
module tb_delay_probe_rx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] timer_now = '0;
   logic        clear_stats = 1'b0;
   logic        meas_valid;
   logic [31:0] meas_seq, meas_delay, delay_min, delay_max;
   logic [31:0] probe_cnt, bad_cnt, other_cnt, gap_cnt;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  fb[64];
   int          flen = 0;

   delay_probe_rx_if u_if ();

   delay_probe_rx #(
      .TS_W        (32),
      .PROBE_ETYPE (16'h88B5),
      .STAT_TMO    (16)
   ) u_dut (
      .rx_clk        (clk),
      .reset_n       (reset_n),
      .mac           (u_if),
      .i_timer_now   (timer_now),
      .i_clear_stats (clear_stats),
      .o_meas_valid  (meas_valid),
      .o_meas_seq    (meas_seq),
      .o_meas_delay  (meas_delay),
      .o_delay_min   (delay_min),
      .o_delay_max   (delay_max),
      .o_probe_cnt   (probe_cnt),
      .o_bad_cnt     (bad_cnt),
      .o_other_cnt   (other_cnt),
      .o_gap_cnt     (gap_cnt)
   );

   always #5 clk = ~clk;

   task automatic build(input logic [15:0] et, input logic [31:0] seq, input logic [31:0] ts,
                        input int len);
      for (int i = 0; i < len; i++) begin
         if (i < 12) fb[i] = 8'(i + 1);
         else if (i == 12) fb[i] = et[15:8];
         else if (i == 13) fb[i] = et[7:0];
         else if (i < 18) fb[i] = 8'(seq >> (8 * (17 - i)));
         else if (i < 22) fb[i] = 8'(ts >> (8 * (21 - i)));
         else fb[i] = 8'(i * 3);
      end
      flen = len;
   endtask

   // kind: 0 none, 1 goodframe, 2 badframe, 3 both; dly = cycles after last dvld byte.
   task automatic send_frame(input logic [31:0] arr, input int kind, input int dly,
                             input logic clr);
      for (int i = 0; i < flen; i++) begin
         @(posedge clk); #1;
         u_if.mac_rx_dvld = 1'b1;
         u_if.mac_rx_data = fb[i];
         timer_now = arr + 32'(i);
      end
      @(posedge clk); #1;
      u_if.mac_rx_dvld = 1'b0;
      u_if.mac_rx_data = 8'h00;
      if (kind != 0) begin
         for (int k = 1; k < dly; k++) begin
            @(posedge clk); #1;
         end
         u_if.mac_rx_goodframe = (kind == 1 || kind == 3);
         u_if.mac_rx_badframe  = (kind >= 2);
         clear_stats = clr;
         @(posedge clk); #1;
         u_if.mac_rx_goodframe = 1'b0;
         u_if.mac_rx_badframe  = 1'b0;
         clear_stats = 1'b0;
      end
   endtask

   task automatic test_reset;
      total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %0h want 0", meas_valid); end
      total++; if (meas_delay !== 32'd0) begin bad++; $display("FAIL rst_delay got %0h want 0", meas_delay); end
      total++; if (delay_min !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_min got %0h want ffffffff", delay_min); end
      total++; if (delay_max !== 32'd0) begin bad++; $display("FAIL rst_max got %0h want 0", delay_max); end
      total++; if (probe_cnt !== 32'd0 || bad_cnt !== 32'd0 || other_cnt !== 32'd0 || gap_cnt !== 32'd0) begin
         bad++; $display("FAIL rst_cnts got %0h/%0h/%0h/%0h want all 0", probe_cnt, bad_cnt, other_cnt, gap_cnt); end
      total++; if ({u_if.conf_rx_en, u_if.conf_rx_jumbo_en, u_if.conf_rx_no_chk_crc} !== 3'b100) begin
         bad++; $display("FAIL rst_conf got %b%b%b want 100", u_if.conf_rx_en, u_if.conf_rx_jumbo_en, u_if.conf_rx_no_chk_crc); end
   endtask

   task automatic test_basic;
      build(16'h88B5, 32'd5, 32'h100, 30);
      send_frame(32'h180, 1, 1, 1'b0);
      total++; if (meas_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %0h want 1", meas_valid); end
      total++; if (meas_seq !== 32'd5) begin bad++; $display("FAIL basic_seq got %0h want 5", meas_seq); end
      total++; if (meas_delay !== 32'h80) begin bad++; $display("FAIL basic_delay got %0h want 80", meas_delay); end
      total++; if (delay_min !== 32'h80 || delay_max !== 32'h80) begin
         bad++; $display("FAIL basic_minmax got %0h/%0h want 80/80", delay_min, delay_max); end
      total++; if (probe_cnt !== 32'd1) begin bad++; $display("FAIL basic_probe_cnt got %0d want 1", probe_cnt); end
      @(posedge clk); #1;
      total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got %0h want 0", meas_valid); end
   endtask

   task automatic test_wrap_gap;
      build(16'h88B5, 32'd6, 32'hFFFF_FFF0, 30);
      send_frame(32'h10, 1, 3, 1'b0);
      total++; if (meas_delay !== 32'h20) begin bad++; $display("FAIL wrap_delay got %0h want 20", meas_delay); end
      total++; if (delay_min !== 32'h20) begin bad++; $display("FAIL wrap_min got %0h want 20", delay_min); end
      build(16'h88B5, 32'd7, 32'h1000, 30);
      send_frame(32'h1005, 1, 1, 1'b0);
      total++; if (gap_cnt !== 32'd0) begin bad++; $display("FAIL gap_none got %0d want 0", gap_cnt); end
      build(16'h88B5, 32'd9, 32'h0, 40);
      send_frame(32'h300, 1, 2, 1'b0);
      total++; if (gap_cnt !== 32'd1) begin bad++; $display("FAIL gap_one got %0d want 1", gap_cnt); end
      total++; if (delay_min !== 32'h5 || delay_max !== 32'h300) begin
         bad++; $display("FAIL gap_minmax got %0h/%0h want 5/300", delay_min, delay_max); end
      total++; if (probe_cnt !== 32'd4) begin bad++; $display("FAIL gap_probe_cnt got %0d want 4", probe_cnt); end
   endtask

   task automatic test_other_bad;
      build(16'h0800, 32'd77, 32'h0, 30);
      send_frame(32'h900, 1, 3, 1'b0);
      total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL other_novalid got %0h want 0", meas_valid); end
      total++; if (other_cnt !== 32'd1) begin bad++; $display("FAIL other_cnt got %0d want 1", other_cnt); end
      build(16'h88B5, 32'd50, 32'h0, 30);
      send_frame(32'h40, 2, 1, 1'b0);
      total++; if (bad_cnt !== 32'd1 || meas_valid !== 1'b0) begin
         bad++; $display("FAIL badframe got cnt=%0d valid=%0h want 1/0", bad_cnt, meas_valid); end
      build(16'h88B5, 32'd51, 32'h0, 16);
      send_frame(32'h40, 1, 1, 1'b0);
      total++; if (other_cnt !== 32'd2 || meas_valid !== 1'b0) begin
         bad++; $display("FAIL runt got cnt=%0d valid=%0h want 2/0", other_cnt, meas_valid); end
      build(16'h88B5, 32'd52, 32'h0, 30);
      send_frame(32'h40, 3, 2, 1'b0);
      total++; if (bad_cnt !== 32'd2 || probe_cnt !== 32'd4) begin
         bad++; $display("FAIL both_status got bad=%0d probe=%0d want 2/4", bad_cnt, probe_cnt); end
      total++; if (meas_seq !== 32'd9) begin bad++; $display("FAIL held_seq got %0d want 9", meas_seq); end
   endtask

   task automatic test_timeout;
      build(16'h88B5, 32'd10, 32'h0, 30);
      send_frame(32'h40, 0, 0, 1'b0);
      repeat (15) begin @(posedge clk); #1; end
      total++; if (bad_cnt !== 32'd2) begin bad++; $display("FAIL tmo_early got %0d want 2", bad_cnt); end
      @(posedge clk); #1;
      total++; if (bad_cnt !== 32'd3) begin bad++; $display("FAIL tmo_hit got %0d want 3", bad_cnt); end
      // Back in idle: a stray goodframe must be ignored.
      u_if.mac_rx_goodframe = 1'b1;
      @(posedge clk); #1;
      u_if.mac_rx_goodframe = 1'b0;
      total++; if (meas_valid !== 1'b0 || other_cnt !== 32'd2 || probe_cnt !== 32'd4) begin
         bad++; $display("FAIL tmo_idle got v=%0h oth=%0d prb=%0d want 0/2/4", meas_valid, other_cnt, probe_cnt); end
   endtask

   task automatic test_back_to_back;
      build(16'h88B5, 32'd20, 32'h0, 30);
      send_frame(32'h40, 0, 0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      build(16'h88B5, 32'd11, 32'h2000, 30);
      send_frame(32'h2040, 1, 2, 1'b0);
      total++; if (bad_cnt !== 32'd4) begin bad++; $display("FAIL b2b_bad got %0d want 4", bad_cnt); end
      total++; if (meas_valid !== 1'b1 || meas_seq !== 32'd11 || meas_delay !== 32'h40) begin
         bad++; $display("FAIL b2b_meas got v=%0h seq=%0d d=%0h want 1/11/40", meas_valid, meas_seq, meas_delay); end
      total++; if (gap_cnt !== 32'd2) begin bad++; $display("FAIL b2b_gap got %0d want 2", gap_cnt); end
      build(16'h88B5, 32'd12, 32'h4000, 30);
      send_frame(32'h4100, 1, 16, 1'b0);
      total++; if (meas_valid !== 1'b1 || meas_delay !== 32'h100 || probe_cnt !== 32'd6) begin
         bad++; $display("FAIL late_status got v=%0h d=%0h prb=%0d want 1/100/6", meas_valid, meas_delay, probe_cnt); end
      total++; if (gap_cnt !== 32'd2 || bad_cnt !== 32'd4) begin
         bad++; $display("FAIL late_cnts got gap=%0d bad=%0d want 2/4", gap_cnt, bad_cnt); end
   endtask

   task automatic test_clear;
      build(16'h88B5, 32'd13, 32'h3000, 30);
      send_frame(32'h3010, 1, 1, 1'b1);
      total++; if (meas_valid !== 1'b1 || meas_seq !== 32'd13 || meas_delay !== 32'h10) begin
         bad++; $display("FAIL clr_meas got v=%0h seq=%0d d=%0h want 1/13/10", meas_valid, meas_seq, meas_delay); end
      total++; if (probe_cnt !== 32'd0 || gap_cnt !== 32'd0 || bad_cnt !== 32'd0 || other_cnt !== 32'd0) begin
         bad++; $display("FAIL clr_cnts got %0d/%0d/%0d/%0d want all 0", probe_cnt, gap_cnt, bad_cnt, other_cnt); end
      total++; if (delay_min !== 32'hFFFF_FFFF || delay_max !== 32'd0) begin
         bad++; $display("FAIL clr_minmax got %0h/%0h want ffffffff/0", delay_min, delay_max); end
      build(16'h88B5, 32'd100, 32'h0, 30);
      send_frame(32'h44, 1, 1, 1'b0);
      total++; if (probe_cnt !== 32'd1 || gap_cnt !== 32'd0) begin
         bad++; $display("FAIL clr_next got prb=%0d gap=%0d want 1/0", probe_cnt, gap_cnt); end
      total++; if (delay_min !== 32'h44 || delay_max !== 32'h44) begin
         bad++; $display("FAIL clr_next_mm got %0h/%0h want 44/44", delay_min, delay_max); end
   endtask

   task automatic test_reset_mid;
      build(16'h88B5, 32'd150, 32'h0, 30);
      for (int i = 0; i < flen; i++) begin
         @(posedge clk); #1;
         u_if.mac_rx_dvld = 1'b1;
         u_if.mac_rx_data = fb[i];
         timer_now = 32'h700 + 32'(i);
         if (i == 16) reset_n = 1'b0;
         if (i == 19) reset_n = 1'b1;
         if (i == 17) begin
            total++; if (probe_cnt !== 32'd0 || delay_min !== 32'hFFFF_FFFF || meas_seq !== 32'd0 ||
                         meas_delay !== 32'd0 || u_if.conf_rx_en !== 1'b1) begin
               bad++; $display("FAIL mid_rst got prb=%0d min=%0h seq=%0d d=%0h en=%0h want 0/ffffffff/0/0/1",
                               probe_cnt, delay_min, meas_seq, meas_delay, u_if.conf_rx_en); end
         end
      end
      @(posedge clk); #1;
      u_if.mac_rx_dvld = 1'b0;
      u_if.mac_rx_goodframe = 1'b1;
      @(posedge clk); #1;
      u_if.mac_rx_goodframe = 1'b0;
      total++; if (meas_valid !== 1'b0 || probe_cnt !== 32'd0 || other_cnt !== 32'd0 || bad_cnt !== 32'd0) begin
         bad++; $display("FAIL mid_abandon got v=%0h prb=%0d oth=%0d bad=%0d want 0/0/0/0",
                         meas_valid, probe_cnt, other_cnt, bad_cnt); end
      build(16'h88B5, 32'd200, 32'h500, 30);
      send_frame(32'h5A0, 1, 1, 1'b0);
      total++; if (meas_valid !== 1'b1 || meas_seq !== 32'd200 || meas_delay !== 32'hA0) begin
         bad++; $display("FAIL mid_next got v=%0h seq=%0d d=%0h want 1/200/a0", meas_valid, meas_seq, meas_delay); end
      total++; if (probe_cnt !== 32'd1 || gap_cnt !== 32'd0 || delay_min !== 32'hA0 || delay_max !== 32'hA0) begin
         bad++; $display("FAIL mid_next_stats got prb=%0d gap=%0d min=%0h max=%0h want 1/0/a0/a0",
                         probe_cnt, gap_cnt, delay_min, delay_max); end
   endtask

   initial begin
      u_if.mac_rx_data      = 8'h00;
      u_if.mac_rx_dvld      = 1'b0;
      u_if.mac_rx_goodframe = 1'b0;
      u_if.mac_rx_badframe  = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      test_reset();
      repeat (2) begin @(posedge clk); #1; end
      test_basic();
      test_wrap_gap();
      test_other_bad();
      test_timeout();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
